// File: rtl/dmw_rmw_pkg.sv
// instr_def: store opcodes shared by the data memory write path
package instr_def;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;
endpackage

// File: rtl/dmw_rmw_merge.sv
// dmw_merge: overlays sb/sh store data onto the old memory word; sw passes wdata through
module dmw_merge
    import instr_def::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_merged
);
    always_comb begin
        o_merged = i_old;
        case (i_op)
            OP_SB:   o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            OP_SH:   o_merged[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
            OP_SW:   o_merged = i_wdata;
            default: o_merged = i_old;
        endcase
    end
endmodule

// File: rtl/dmw_rmw.sv
// dmw_rmw: store-side read-modify-write controller; DMW_MISALIGN_EXC_EN enables misaligned-store exceptions
module dmw_rmw
    import instr_def::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              exc,
    output logic [ADDR_W-1:0] exc_addr
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} state_t;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] LAST = CW'(RD_LAT - 1);

    state_t            r_state, w_next;
    logic [5:0]        r_op;
    logic [1:0]        r_lane;
    logic [ADDR_W-3:0] r_waddr;
    logic [31:0]       r_wdata, r_merge, w_merged;
    logic [CW-1:0]     r_cnt;
    logic              w_acc, w_store, w_mis, w_last;

    assign w_acc   = req_valid && r_state == S_IDLE;
    assign w_store = op == OP_SB || op == OP_SH || op == OP_SW;
    assign w_last  = r_state == S_WAIT && r_cnt == LAST;

`ifdef DMW_MISALIGN_EXC_EN
    logic              r_exc;
    logic [ADDR_W-1:0] r_exc_addr;
    assign w_mis    = (op == OP_SH && addr[0]) || (op == OP_SW && addr[1:0] != 2'b00);
    assign exc      = r_exc;
    assign exc_addr = r_exc_addr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exc      <= 1'b0;
            r_exc_addr <= '0;
        end else begin
            r_exc <= w_acc && w_mis;
            if (w_acc)
                r_exc_addr <= w_mis ? addr : '0;
        end
    end
`else
    assign w_mis    = 1'b0;
    assign exc      = 1'b0;
    assign exc_addr = '0;
`endif

    dmw_merge u_merge (
        .i_op     (r_op),
        .i_lane   (r_lane),
        .i_old    (mem_rdata),
        .i_wdata  (r_wdata),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_acc && w_store && !w_mis) w_next = (op == OP_SW) ? S_WR : S_RD;
            S_RD:    w_next = S_WAIT;
            S_WAIT:  if (w_last) w_next = S_WR;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= '0;
            r_lane  <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_merge <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_acc && w_store) begin
                r_op    <= op;
                r_lane  <= addr[1:0];
                r_waddr <= addr[ADDR_W-1:2];
                r_wdata <= wdata;
            end
            // sw skips the read, so its word goes straight into the merge register
            if (w_acc && op == OP_SW)
                r_merge <= wdata;
            else if (w_last)
                r_merge <= w_merged;
            r_cnt <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
        end
    end

    assign req_ready = r_state == S_IDLE;
    assign mem_rd_en = r_state == S_RD;
    assign mem_wr_en = r_state == S_WR;
    assign done      = r_state == S_WR;
    assign mem_addr  = r_waddr;
    assign mem_wdata = r_merge;
endmodule

// File: tb/tb_dmw_rmw.sv
// tb_dmw_rmw: directed table-driven bench for dmw_rmw with a one-cycle-latency memory model
module tb_dmw_rmw;
    import instr_def::*;

    logic        clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0, mem_word = '0;
    logic        req_ready, mem_rd_en, mem_wr_en, done, exc;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, exc_addr;
    int          n_tests = 0, n_fail = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr, wdata, old, exp;
        logic [29:0] waddr;
        int          lat;
    } vec_t;
    vec_t vecs[9];

    dmw_rmw #(.ADDR_W(32), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .addr(addr), .wdata(wdata), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .done(done), .exc(exc), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_rd_en) mem_rdata <= mem_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc;
        logic rd_seen;
        @(negedge clk);
        mem_word = v.old; op = v.op; addr = v.addr; wdata = v.wdata; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        rd_seen = 1'b0;
        chk($sformatf("v%0d ready_busy", idx), {31'd0, req_ready}, 32'd0);
        while (!mem_wr_en && cyc < 12) begin
            rd_seen |= mem_rd_en;
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("v%0d wr_cycle", idx), cyc, v.lat);
        chk($sformatf("v%0d wdata", idx), mem_wdata, v.exp);
        chk($sformatf("v%0d waddr", idx), {2'b00, mem_addr}, {2'b00, v.waddr});
        chk($sformatf("v%0d done", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d rd_seen", idx), {31'd0, rd_seen}, {31'd0, v.op != OP_SW});
        @(posedge clk); #1;
        chk($sformatf("v%0d ready_after", idx), {31'd0, req_ready}, 32'd1);
        chk($sformatf("v%0d done_clear", idx), {31'd0, done}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{OP_SW, 32'h100, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 30'h40, 1};
        vecs[1] = '{OP_SB, 32'h102, 32'h000000AB, 32'h11223344, 32'h11AB3344, 30'h40, 3};
        vecs[2] = '{OP_SH, 32'h206, 32'h0000CAFE, 32'h55667788, 32'hCAFE7788, 30'h81, 3};
        vecs[3] = '{OP_SB, 32'h000, 32'hFFFFFF5A, 32'h11223344, 32'h1122335A, 30'h0, 3};
        vecs[4] = '{OP_SB, 32'h001, 32'h00000077, 32'hAAAAAAAA, 32'hAAAA77AA, 30'h0, 3};
        vecs[5] = '{OP_SB, 32'h003, 32'h000000C3, 32'h00000000, 32'hC3000000, 30'h0, 3};
        vecs[6] = '{OP_SH, 32'h000, 32'h9999BEEF, 32'h12345678, 32'h1234BEEF, 30'h0, 3};
        vecs[7] = '{OP_SW, 32'hFFFFFFFC, 32'h01020304, 32'h0, 32'h01020304, 30'h3FFFFFFF, 1};
        vecs[8] = '{OP_SH, 32'h00C, 32'h00001357, 32'hFFFFFFFF, 32'hFFFF1357, 30'h3, 3};

        #2;
        chk("rst ready", {31'd0, req_ready}, 32'd1);
        chk("rst outs", {28'd0, mem_rd_en, mem_wr_en, done, exc}, 32'd0);
        chk("rst wdata", mem_wdata, 32'd0);
        chk("rst maddr", {2'b00, mem_addr}, 32'd0);
        chk("rst exc_addr", exc_addr, 32'd0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // non-store request is dropped without any memory activity
        @(negedge clk);
        op = 6'b100011; addr = 32'h40; req_valid = 1'b1;
        @(negedge clk) req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("nonstore c%0d", c), {28'd0, req_ready, mem_rd_en, mem_wr_en, done}, 32'h8);
            @(negedge clk);
        end

        // back-to-back sh then sb with req_valid held
        mem_word = 32'h11223344;
        op = OP_SH; addr = 32'h002; wdata = 32'h0000BEEF; req_valid = 1'b1;
        @(posedge clk); #1;
        op = OP_SB; addr = 32'h001; wdata = 32'h00000099;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("b2b ready c%0d", c), {31'd0, req_ready}, {31'd0, c == 4 || c == 8});
            chk($sformatf("b2b rd c%0d", c), {31'd0, mem_rd_en}, {31'd0, c == 1 || c == 5});
            chk($sformatf("b2b wr c%0d", c), {30'd0, mem_wr_en, done}, (c == 3 || c == 7) ? 32'd3 : 32'd0);
            if (c == 3) chk("b2b wdata1", mem_wdata, 32'hBEEF3344);
            if (c == 7) chk("b2b wdata2", mem_wdata, 32'h11229944);
            if (c == 5) req_valid = 1'b0;
            @(posedge clk); #1;
        end

        // reset asserted while waiting for read data
        @(negedge clk);
        op = OP_SB; addr = 32'h10C; wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstmid in_wait", {30'd0, req_ready, mem_rd_en}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rstmid ready", {31'd0, req_ready}, 32'd1);
        chk("rstmid outs", {29'd0, mem_rd_en, mem_wr_en, done}, 32'd0);
        chk("rstmid maddr", {2'b00, mem_addr}, 32'd0);
        chk("rstmid wdata", mem_wdata, 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("rstmid quiet c%0d", c), {30'd0, mem_wr_en, done}, 32'd0);
            @(negedge clk);
        end

`ifdef DMW_MISALIGN_EXC_EN
        op = OP_SW; addr = 32'h103; wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mis exc", {31'd0, exc}, 32'd1);
        chk("mis exc_addr", exc_addr, 32'h103);
        chk("mis quiet", {28'd0, req_ready, mem_rd_en, mem_wr_en, done}, 32'h8);
        @(posedge clk); #1;
        chk("mis exc_clear", {31'd0, exc}, 32'd0);
        chk("mis exc_hold", exc_addr, 32'h103);
        chk("mis quiet2", {29'd0, mem_rd_en, mem_wr_en, done}, 32'd0);
`else
        run_vec('{OP_SW, 32'h103, 32'h12345678, 32'h0, 32'h12345678, 30'h40, 1}, 9);
        chk("noexc exc", {31'd0, exc}, 32'd0);
        chk("noexc exc_addr", exc_addr, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
